// File: rtl/stream_sink.sv
// Terminal stream consumer: captures a fixed-length word stream into a circular
// buffer, counts accepted words, flags completion and overflow, and serves host reads.
module stream_sink #(
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          EN,
  input  logic          R_IN,
  input  logic [N-1:0]  D_IN,
  input  logic          START,
  input  logic [CW-1:0] EXPECT,
  input  logic          RD_EN,
  output logic [N-1:0]  RD_DATA,
  output logic          RD_VALID,
  output logic          EMPTY,
  output logic          FULL,
  output logic [CW-1:0] RECEIVED,
  output logic          BUSY,
  output logic          DONE,
  output logic          OVERFLOW
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] expect_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [OW-1:0] count_q;
  logic [N-1:0]  mem [DEPTH];

  logic          accept_c;
  logic          do_wr_c;
  logic          do_rd_c;
  logic          last_word_c;
  logic [OW-1:0] count_nxt_c;

  // FULL/EMPTY are the registered flags, so a read never frees space for a same-cycle write.
  assign accept_c    = (state_q == S_CAPTURE) && EN && R_IN;
  assign do_wr_c     = accept_c && !FULL;
  assign do_rd_c     = RD_EN && !EMPTY;
  assign last_word_c = (RECEIVED + CW'(1)) == expect_q;

  always_comb begin
    count_nxt_c = count_q;
    if (do_wr_c && !do_rd_c) begin
      count_nxt_c = count_q + OW'(1);
    end else if (do_rd_c && !do_wr_c) begin
      count_nxt_c = count_q - OW'(1);
    end
  end

  // Buffer storage; contents are don't-care after reset or START.
  always_ff @(posedge CLK) begin
    if (do_wr_c && !START) begin
      mem[wr_ptr_q] <= D_IN;
    end
  end

  // Control FSM, pointers, counters and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      expect_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      RD_DATA  <= '0;
      RD_VALID <= 1'b0;
      EMPTY    <= 1'b1;
      FULL     <= 1'b0;
      RECEIVED <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      RD_VALID <= 1'b0;
      if (START) begin
        expect_q <= EXPECT;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        EMPTY    <= 1'b1;
        FULL     <= 1'b0;
        RECEIVED <= '0;
        OVERFLOW <= 1'b0;
        if (EXPECT == '0) begin
          state_q <= S_DONE;
          BUSY    <= 1'b0;
          DONE    <= 1'b1;
        end else begin
          state_q <= S_CAPTURE;
          BUSY    <= 1'b1;
          DONE    <= 1'b0;
        end
      end else begin
        if (do_wr_c) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (do_rd_c) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
          RD_DATA  <= mem[rd_ptr_q];
          RD_VALID <= 1'b1;
        end
        count_q <= count_nxt_c;
        EMPTY   <= (count_nxt_c == '0);
        FULL    <= (count_nxt_c == OW'(DEPTH));
        if (accept_c) begin
          RECEIVED <= RECEIVED + CW'(1);
          if (FULL) begin
            OVERFLOW <= 1'b1;
          end
          if (last_word_c) begin
            state_q <= S_DONE;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/stream_sink.md
# stream_sink

Terminal consumer for the team's ready-qualified dataflow streams (CLK/EN/R_IN/D_IN). It captures a fixed-length result stream from an operator chain such as the immediate-arithmetic nodes into a circular buffer, counts the words, and flags completion. A host-side read port drains the buffer, and a sticky flag records words lost to overflow.

## Interface
- N, 16: data word width.
- DEPTH, 16: buffer entries; power of two, ≥2; AW = log2(DEPTH).
- CW, 16: width of the expected and received word counters.

- CLK  input  1  clock, rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- EN  input  1  stream enable; no word is accepted while low.
- R_IN  input  1  word-valid strobe from upstream operator.
- D_IN  input  N  stream data.
- START  input  1  one-cycle pulse that arms or re-arms a capture.
- EXPECT  input  CW  words to capture; sampled on START.
- RD_EN  input  1  host read request.
- RD_DATA  output  N  read data; valid when RD_VALID=1.
- RD_VALID  output  1  one-cycle pulse qualifying RD_DATA.
- EMPTY  output  1  buffer occupancy is 0.
- FULL  output  1  buffer occupancy is DEPTH.
- RECEIVED  output  CW  words accepted since the last START, including dropped words.
- BUSY  output  1  FSM in CAPTURE.
- DONE  output  1  FSM in DONE.
- OVERFLOW  output  1  sticky: at least one word was dropped since the last START.

## Operation
- FSM states are IDLE, CAPTURE and DONE.
- Reset state is IDLE.
- Reset values: RD_DATA=0, RD_VALID=0, EMPTY=1, FULL=0, RECEIVED=0, BUSY=0, DONE=0, OVERFLOW=0. Pointers and occupancy reset to 0.
- START in any state does the following:
  - latches EXPECT;
  - clears the write pointer, read pointer, occupancy, RECEIVED and OVERFLOW;
  - goes to CAPTURE, or goes to DONE if EXPECT=0.
  - START has priority over a write or read in the same cycle; both are ignored.
- Accept condition: state=CAPTURE && EN && R_IN. In IDLE and DONE, stream words are ignored with no side effects.
- On accept:
  - RECEIVED increments.
  - If FULL=0 (registered value), D_IN is written at the write pointer, which increments modulo DEPTH.
  - If FULL=1, the word is dropped and OVERFLOW is set. This holds even when a read occurs in the same cycle.
  - If RECEIVED+1 = EXPECT, the FSM goes to DONE.
- DONE holds until the next START or reset.
- Reads are allowed in every state:
  - RD_EN with EMPTY=0 (registered value) pops the entry at the read pointer, which increments modulo DEPTH.
  - RD_EN with EMPTY=1 is ignored and RD_VALID stays 0, even when a write occurs in the same cycle.
- Occupancy update per cycle:
  - write only: +1;
  - read only: −1;
  - both: unchanged;
  - otherwise: held.
- EMPTY and FULL are registered from the next occupancy.
- Counter arithmetic is unsigned CW bits. Completion is an equality compare, so RECEIVED never passes EXPECT.
- Asserting RST_N low mid-capture immediately returns every output to its reset value. Buffer contents are discarded.

## Timing
- Write latency:
  - Word accepted at edge k: EMPTY falls and RECEIVED updates after edge k.
  - The word is readable by an RD_EN sampled at edge k+1.
- Read latency:
  - RD_EN sampled at edge k: RD_DATA and RD_VALID are presented after edge k.
  - RD_VALID is high for exactly one cycle per successful pop. RD_DATA holds its value otherwise.
- DONE and BUSY change after the same edge that accepts the EXPECT-th word.
- START at edge k: BUSY=1 (or DONE=1 if EXPECT=0) and all counters are cleared after edge k.
- Back-to-back accepts at one word per cycle are supported. Simultaneous read and write sustain full throughput.

## Test plan
- Basic capture:
  - Stimulus: reset, START with EXPECT=4, then words 0x0011, 0x0022, 0x0033, 0x0044 on consecutive cycles with EN=1.
  - Response: DONE after the 4th edge, RECEIVED=4. Four RD_EN cycles return the words in that order with RD_VALID pulses, then EMPTY=1.
- Gating:
  - Stimulus: R_IN=1 with EN=0, and R_IN=1 in IDLE.
  - Response: RECEIVED stays 0 and EMPTY stays 1.
- Overflow:
  - Stimulus: DEPTH=16, EXPECT=20, 20 words with no reads.
  - Response: FULL=1 after 16 words, OVERFLOW=1 from word 17, RECEIVED=20, DONE=1. Reads return only the first 16 words.
- Concurrent traffic and boundary reads:
  - Stimulus: continuous writes with RD_EN every cycle, EXPECT=40, DEPTH=16.
  - Response: occupancy stays ≤1, wrap-around is exercised at least twice, all 40 words are read in order, OVERFLOW=0.
  - Also check: RD_EN while EMPTY gives no RD_VALID.
- Restart and reset:
  - Stimulus: START mid-capture after 3 words, with a word presented in the same cycle.
  - Response: RECEIVED=0, EMPTY=1, the presented word is ignored.
  - Stimulus: RST_N low mid-capture, driven asynchronously between clock edges.
  - Response: all outputs return to reset values immediately. EXPECT=0 on START gives DONE after one edge.
